// File: rtl/acc_controller.sv
// acc_controller: multicycle fetch/decode/execute control FSM for the 16-bit accumulator datapath.
// Build option: define ILLEGAL_TRAP_EN to trap undefined opcodes to HALT with fault set.
module acc_controller #(
  parameter int MUL_TIMEOUT = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [7:0]       opcode,
  input  logic             zflag,
  input  logic             mult_done,
  output logic             muxPC,
  output logic             muxMAR,
  output logic             loadMAR,
  output logic             loadPC,
  output logic             loadACC,
  output logic             loadMDR,
  output logic             loadIR,
  output logic [1:0]       muxACC,
  output logic [1:0]       opALU,
  output logic             mult_load,
  output logic             mult_reset,
  output logic             mem_we,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  localparam int TMO_W = $clog2(MUL_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MUL_TIMEOUT - 1);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h10;
  localparam logic [7:0] OP_SUB   = 8'h11;
  localparam logic [7:0] OP_AND   = 8'h12;
  localparam logic [7:0] OP_OR    = 8'h13;
  localparam logic [7:0] OP_MUL   = 8'h20;
  localparam logic [7:0] OP_CLR   = 8'h21;
  localparam logic [7:0] OP_JMP   = 8'h30;
  localparam logic [7:0] OP_JZ    = 8'h31;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [1:0] ACC_ALU  = 2'b00;
  localparam logic [1:0] ACC_MDR  = 2'b01;
  localparam logic [1:0] ACC_MUL  = 2'b10;
  localparam logic [1:0] ACC_ZERO = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_A0, S_A1, S_S0,
    S_S1, S_M0, S_M1, S_M2, S_W, S_J, S_RET, S_HALT
  } state_t;

  typedef struct packed {
    logic       mux_pc;
    logic       mux_mar;
    logic       load_mar;
    logic       load_pc;
    logic       load_acc;
    logic       load_mdr;
    logic       load_ir;
    logic [1:0] mux_acc;
    logic [1:0] op_alu;
    logic       mult_load;
    logic       mult_reset;
    logic       mem_we;
    logic       halted;
  } ctl_t;

  state_t           state, state_nxt;
  ctl_t             ctl_q, ctl_nxt;
  logic [1:0]       acc_sel, acc_sel_nxt;
  logic [1:0]       alu_sel, alu_sel_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic             fault_q, fault_set, retire;
  logic [CNT_W-1:0] cnt_q;

  // Multiplier handshake: mult_load presents operands (valid) for one cycle; mult_done is the
  // result-valid, consumed in M2 and committed by the W load. No backpressure exists on either side.
  always_comb begin
    state_nxt   = state;
    acc_sel_nxt = acc_sel;
    alu_sel_nxt = alu_sel;
    tmo_nxt     = tmo_cnt;
    fault_set   = 1'b0;
    retire      = 1'b0;
    unique case (state)
      S_IDLE: if (run) state_nxt = S_F0;
      S_F0:   state_nxt = S_F1;
      S_F1:   state_nxt = S_F2;
      S_F2:   state_nxt = S_DEC;
      S_DEC: begin
        acc_sel_nxt = ACC_ALU;
        alu_sel_nxt = 2'b00;
        case (opcode)
          OP_NOP:   state_nxt = S_RET;
          OP_LOAD: begin
            state_nxt   = S_A0;
            acc_sel_nxt = ACC_MDR;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            state_nxt   = S_A0;
            alu_sel_nxt = opcode[1:0];
          end
          OP_MUL: begin
            state_nxt   = S_A0;
            acc_sel_nxt = ACC_MUL;
          end
          OP_STORE: state_nxt = S_S0;
          OP_CLR: begin
            state_nxt   = S_W;
            acc_sel_nxt = ACC_ZERO;
          end
          OP_JMP:   state_nxt = S_J;
          OP_JZ:    state_nxt = zflag ? S_J : S_RET;
          OP_HALT:  state_nxt = S_HALT;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            fault_set = 1'b1;
            state_nxt = S_HALT;
`else
            state_nxt = S_RET;
`endif
          end
        endcase
      end
      S_A0: state_nxt = S_A1;
      S_A1: state_nxt = (acc_sel == ACC_MUL) ? S_M0 : S_W;
      S_S0: state_nxt = S_S1;
      S_S1: state_nxt = S_RET;
      S_M0: state_nxt = S_M1;
      S_M1: begin
        tmo_nxt   = '0;
        state_nxt = S_M2;
      end
      S_M2: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (mult_done) begin
          state_nxt = S_W;
        end else if (tmo_cnt == TMO_LAST) begin
          fault_set = 1'b1;
          state_nxt = S_HALT;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      S_W:   state_nxt = S_RET;
      S_J:   state_nxt = S_RET;
      S_RET: begin
        retire    = 1'b1;
        state_nxt = run ? S_F0 : S_IDLE;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Controls are decoded from the next state and registered, so every output comes straight
  // from a flop and is stable for the whole cycle the FSM spends in that state.
  always_comb begin
    ctl_nxt = '0;
    case (state_nxt)
      S_F0: ctl_nxt.load_mar = 1'b1;
      S_F1: ctl_nxt.load_mdr = 1'b1;
      S_F2: begin
        ctl_nxt.load_ir = 1'b1;
        ctl_nxt.load_pc = 1'b1;
      end
      S_A0, S_S0: begin
        ctl_nxt.load_mar = 1'b1;
        ctl_nxt.mux_mar  = 1'b1;
      end
      S_A1:   ctl_nxt.load_mdr   = 1'b1;
      S_S1:   ctl_nxt.mem_we     = 1'b1;
      S_M0:   ctl_nxt.mult_reset = 1'b1;
      S_M1:   ctl_nxt.mult_load  = 1'b1;
      S_W:    ctl_nxt.load_acc   = 1'b1;
      S_J: begin
        ctl_nxt.load_pc = 1'b1;
        ctl_nxt.mux_pc  = 1'b1;
      end
      S_HALT: ctl_nxt.halted = 1'b1;
      default: ;
    endcase
    // The ACC source and ALU function stay put from the state after DEC through W.
    if (state_nxt inside {S_A0, S_A1, S_M0, S_M1, S_M2, S_W}) begin
      ctl_nxt.mux_acc = acc_sel_nxt;
      ctl_nxt.op_alu  = alu_sel_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ctl_q   <= '0;
      acc_sel <= ACC_ALU;
      alu_sel <= 2'b00;
      tmo_cnt <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      ctl_q   <= ctl_nxt;
      acc_sel <= acc_sel_nxt;
      alu_sel <= alu_sel_nxt;
      tmo_cnt <= tmo_nxt;
      if (fault_set) fault_q <= 1'b1;
      if (retire)    cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign muxPC       = ctl_q.mux_pc;
  assign muxMAR      = ctl_q.mux_mar;
  assign loadMAR     = ctl_q.load_mar;
  assign loadPC      = ctl_q.load_pc;
  assign loadACC     = ctl_q.load_acc;
  assign loadMDR     = ctl_q.load_mdr;
  assign loadIR      = ctl_q.load_ir;
  assign muxACC      = ctl_q.mux_acc;
  assign opALU       = ctl_q.op_alu;
  assign mult_load   = ctl_q.mult_load;
  assign mult_reset  = ctl_q.mult_reset;
  assign mem_we      = ctl_q.mem_we;
  assign halted      = ctl_q.halted;
  assign fault       = fault_q;
  assign instr_count = cnt_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_acc_controller.sv
// tb_acc_controller: drives acc_controller with a behavioural datapath and checks programs
// against an instruction-level reference model (ISA semantics plus per-instruction cycle table).
module tb_acc_controller;

  localparam int MUL_TIMEOUT = 32;
  localparam int CNT_W       = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic [7:0]       opcode;
  logic             zflag, mult_done;
  logic             muxPC, muxMAR, loadMAR, loadPC, loadACC, loadMDR, loadIR;
  logic [1:0]       muxACC, opALU;
  logic             mult_load, mult_reset, mem_we, halted, fault;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state_dbg;
  logic [14:0]      ctl_all;

  acc_controller #(.MUL_TIMEOUT(MUL_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zflag(zflag), .mult_done(mult_done),
    .muxPC(muxPC), .muxMAR(muxMAR), .loadMAR(loadMAR), .loadPC(loadPC), .loadACC(loadACC),
    .loadMDR(loadMDR), .loadIR(loadIR), .muxACC(muxACC), .opALU(opALU),
    .mult_load(mult_load), .mult_reset(mult_reset), .mem_we(mem_we), .halted(halted),
    .fault(fault), .instr_count(instr_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- datapath environment ----------------
  logic [15:0] mem [256];
  logic [7:0]  pc, mar;
  logic [15:0] mdr, ir, acc, mul_prod;
  logic        mul_busy = 1'b0, mul_hang = 1'b0;
  int          mul_cnt = 0, mul_delay = 1;
  int          cyc = 0;
  int          fetch_t[$];
  logic [7:0]  fetch_a[$];
  int          we_cnt, rst_cnt, ld_cnt, acc_mul_cnt, acc_ld_cnt, t_reset, t_load, t_halt;

  assign opcode    = ir[7:0];
  assign zflag     = (acc == 16'h0000);
  assign mult_done = mul_busy && (mul_cnt == 0) && !mul_hang;
  assign ctl_all   = {muxPC, muxMAR, loadMAR, loadPC, loadACC, loadMDR, loadIR,
                      muxACC, opALU, mult_load, mult_reset, mem_we, halted};

  // ---------------- scoreboard ----------------
  int          vectors = 0, miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_mem [256];
  logic [15:0] exp_acc;
  logic [7:0]  exp_pc;
  int          exp_cnt, exp_fault, exp_stores, exp_muls, exp_mul_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Datapath registers update mid-cycle from the controls of the current cycle.
  task automatic dp_step();
    cyc++;
    if (!rst) begin
      pc = 0; mar = 0; mdr = 0; ir = 0; acc = 0; mul_busy = 1'b0; mul_cnt = 0;
    end else begin
      if (loadMAR && !muxMAR) begin fetch_t.push_back(cyc); fetch_a.push_back(pc); end
      if (mem_we) we_cnt++;
      if (mult_reset) begin rst_cnt++; t_reset = cyc; end
      if (mult_load) begin ld_cnt++; t_load = cyc; end
      if (loadACC) acc_ld_cnt++;
      if (loadACC && muxACC == 2'b10) acc_mul_cnt++;
      if (halted && t_halt < 0) t_halt = cyc;
      if (mult_reset) mul_busy = 1'b0;
      if (mult_load) begin
        mul_prod = {8'h00, acc[7:0]} * {8'h00, mdr[7:0]};
        mul_busy = 1'b1;
        mul_cnt  = mul_delay;
      end else if (mul_busy && mul_cnt > 0) begin
        mul_cnt--;
      end
      if (mem_we) mem[mar] = acc;
      if (loadACC) begin
        case (muxACC)
          2'b00: case (opALU)
                   2'b00: acc = acc + mdr;
                   2'b01: acc = acc - mdr;
                   2'b10: acc = acc & mdr;
                   default: acc = acc | mdr;
                 endcase
          2'b01: acc = mdr;
          2'b10: acc = mul_prod;
          default: acc = 16'h0000;
        endcase
      end
      if (loadMDR) mdr = mem[mar];
      if (loadIR)  ir  = mdr;
      if (loadPC)  pc  = muxPC ? ir[15:8] : pc + 8'd1;
      if (loadMAR) mar = muxMAR ? ir[15:8] : pc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    dp_step();
  endtask

  // ---------------- reference model ----------------
  task automatic model_run();
    logic [15:0] a;
    logic [7:0]  p, op, ad;
    bit          done;
    a = 16'h0000; p = 8'h00; done = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    exp_q.delete();
    exp_fault = 0; exp_stores = 0; exp_muls = 0; exp_mul_start = 0;
    for (int step = 0; step < 300 && !done; step++) begin
      op = exp_mem[p][7:0];
      ad = exp_mem[p][15:8];
      p  = p + 8'd1;
      case (op)
        8'h00: exp_q.push_back(8'd5);
        8'h01: begin a = exp_mem[ad]; exp_q.push_back(8'd8); end
        8'h10: begin a = a + exp_mem[ad]; exp_q.push_back(8'd8); end
        8'h11: begin a = a - exp_mem[ad]; exp_q.push_back(8'd8); end
        8'h12: begin a = a & exp_mem[ad]; exp_q.push_back(8'd8); end
        8'h13: begin a = a | exp_mem[ad]; exp_q.push_back(8'd8); end
        8'h20: begin
          exp_mul_start++;
          if (mul_hang) begin
            exp_fault = 1; done = 1;
          end else begin
            a = {8'h00, a[7:0]} * {8'h00, exp_mem[ad][7:0]};
            exp_muls++;
            exp_q.push_back(8'(10 + mul_delay));
          end
        end
        8'h02: begin exp_mem[ad] = a; exp_stores++; exp_q.push_back(8'd7); end
        8'h21: begin a = 16'h0000; exp_q.push_back(8'd6); end
        8'h30: begin p = ad; exp_q.push_back(8'd6); end
        8'h31: if (a == 16'h0000) begin p = ad; exp_q.push_back(8'd6); end
               else exp_q.push_back(8'd5);
        8'hFF: done = 1;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          exp_fault = 1; done = 1;
`else
          exp_q.push_back(8'd5);
`endif
        end
      endcase
    end
    exp_acc = a;
    exp_pc  = p;
    exp_cnt = exp_q.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h00FF;
  endtask

  task automatic put(input logic [7:0] addr, input logic [7:0] op, input logic [7:0] operand);
    mem[addr] = {operand, op};
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    fetch_t.delete(); fetch_a.delete();
    we_cnt = 0; rst_cnt = 0; ld_cnt = 0; acc_mul_cnt = 0; acc_ld_cnt = 0;
    t_reset = -1; t_load = -1; t_halt = -1;
  endtask

  task automatic run_to_halt(input int max_cyc);
    run = 1'b1;
    for (int n = 0; n < max_cyc && !halted; n++) tick();
    run = 1'b0;
    tick();
  endtask

  task automatic check_gap(input int i, input int exp);
    if (fetch_t.size() > i + 1) check("gap", fetch_t[i+1] - fetch_t[i], exp);
    else check("gap_missing", fetch_t.size(), i + 2);
  endtask

  task automatic check_results();
    check("halted", halted, 1);
    check("fault", fault, exp_fault);
    check("instr_count", instr_count, exp_cnt);
    check("acc", acc, exp_acc);
    check("pc", pc, exp_pc);
    check("fetches", fetch_t.size(), exp_q.size() + 1);
    for (int i = 0; i < exp_q.size(); i++) check_gap(i, exp_q[i]);
    check("mem_we_cycles", we_cnt, exp_stores);
    check("mult_reset_pulses", rst_cnt, exp_mul_start);
    check("mult_load_pulses", ld_cnt, exp_mul_start);
    check("acc_from_mul", acc_mul_cnt, exp_muls);
    for (int i = 0; i < 256; i++) check("mem", mem[i], exp_mem[i]);
  endtask

  task automatic gen_random_prog();
    int n, k, t;
    logic [7:0] op, ad;
    clear_mem();
    for (int a = 8'hC0; a < 256; a++) mem[a] = 16'($urandom());
    n = $urandom_range(4, 12);
    for (int i = 0; i < n - 1; i++) begin
      k  = $urandom_range(0, 12);
      ad = 8'($urandom_range(8'hC0, 8'hFF));
      t  = i + 1 + $urandom_range(0, 2);
      if (t > n - 1) t = n - 1;
      case (k)
        0:       op = 8'h00;
        1, 2:    op = 8'h01;
        3:       op = 8'h02;
        4:       op = 8'h10;
        5:       op = 8'h11;
        6:       op = 8'h12;
        7:       op = 8'h13;
        8:       op = 8'h20;
        9:       op = 8'h21;
        10:      begin op = 8'h30; ad = 8'(t); end
        11:      begin op = 8'h31; ad = 8'(t); end
        default: op = 8'h77;
      endcase
      put(8'(i), op, ad);
    end
    put(8'(n - 1), 8'hFF, 8'h00);
    mul_delay = $urandom_range(1, 6);
    mul_hang  = ($urandom_range(0, 9) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset and idle: nothing moves while run is low.
    clear_mem();
    do_reset();
    for (int i = 0; i < 10; i++) check("idle_ctl", ctl_all, 15'h0);
    for (int i = 0; i < 10; i++) tick();
    check("idle_count", instr_count, 0);
    check("idle_fault", fault, 0);
    check("idle_fetch", fetch_t.size(), 0);

    // LOAD / ADD / STORE / HALT.
    clear_mem();
    put(8'h00, 8'h01, 8'h40); put(8'h01, 8'h10, 8'h41);
    put(8'h02, 8'h02, 8'h42); put(8'h03, 8'hFF, 8'h00);
    mem[8'h40] = 16'h0005; mem[8'h41] = 16'h0003;
    mul_delay = 1; mul_hang = 1'b0;
    do_reset(); model_run(); run_to_halt(200); check_results();
    check("store_val", mem[8'h42], 16'h0008);
    check("store_count", instr_count, 3);
    check("store_we", we_cnt, 1);
    check_gap(0, 8); check_gap(1, 8); check_gap(2, 7);

    // MUL completes after 4 wait cycles.
    clear_mem();
    put(8'h00, 8'h01, 8'h40); put(8'h01, 8'h20, 8'h41); put(8'h02, 8'hFF, 8'h00);
    mem[8'h40] = 16'h000A; mem[8'h41] = 16'h000C;
    mul_delay = 4; mul_hang = 1'b0;
    do_reset(); model_run(); run_to_halt(200); check_results();
    check("mul_acc", acc, 16'h0078);
    check("mul_seq", t_load - t_reset, 1);
    check("mul_wb", acc_mul_cnt, 1);
    check_gap(1, 14);

    // MUL timeout.
    mul_hang = 1'b1;
    do_reset(); model_run(); run_to_halt(200); check_results();
    check("tmo_len", t_halt - t_load, MUL_TIMEOUT + 1);
    check("tmo_fault", fault, 1);
    check("tmo_ldacc", acc_ld_cnt, 1);
    mul_hang = 1'b0;

    // CLR then JZ taken.
    clear_mem();
    put(8'h00, 8'h21, 8'h00); put(8'h01, 8'h31, 8'h20);
    do_reset(); model_run(); run_to_halt(200); check_results();
    check("jz_taken_pc", pc, 8'h21);
    check_gap(1, 6);

    // ACC=1 then JZ not taken.
    clear_mem();
    put(8'h00, 8'h01, 8'h40); put(8'h01, 8'h31, 8'h20); mem[8'h40] = 16'h0001;
    do_reset(); model_run(); run_to_halt(200); check_results();
    check("jz_fall_pc", pc, 8'h03);
    check_gap(1, 5);

    // JMP redirects the next fetch.
    clear_mem();
    put(8'h00, 8'h30, 8'h80);
    do_reset(); model_run(); run_to_halt(200); check_results();
    check("jmp_fetch", (fetch_a.size() > 1) ? fetch_a[1] : 8'h00, 8'h80);

    // Undefined opcode.
    clear_mem();
    put(8'h00, 8'h77, 8'h00);
    do_reset(); model_run(); run_to_halt(200); check_results();
`ifdef ILLEGAL_TRAP_EN
    check("illegal_fault", fault, 1);
    check("illegal_count", instr_count, 0);
`else
    check("illegal_count", instr_count, 1);
    check_gap(0, 5);
`endif

    // run dropped after one instruction returns to IDLE, then resumes.
    clear_mem();
    put(8'h00, 8'h00, 8'h00); put(8'h01, 8'h00, 8'h00);
    do_reset();
    run = 1'b1; tick(); run = 1'b0;
    repeat (15) tick();
    check("drop_count", instr_count, 1);
    check("drop_halted", halted, 0);
    check("drop_fetch", fetch_t.size(), 1);
    check("drop_ctl", ctl_all, 15'h0);
    run_to_halt(100);
    check("resume_count", instr_count, 2);
    check("resume_halted", halted, 1);

    // Asynchronous reset during the multiplier wait.
    clear_mem();
    put(8'h00, 8'h01, 8'h40); put(8'h01, 8'h20, 8'h41);
    mul_hang = 1'b1;
    do_reset();
    run = 1'b1;
    for (int n = 0; n < 100 && t_load < 0; n++) tick();
    check("m2_reached", t_load >= 0, 1);
    repeat (5) tick();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("arst_ctl", ctl_all, 15'h0);
    check("arst_count", instr_count, 0);
    check("arst_fault", fault, 0);
    run = 1'b0;
    tick(); rst = 1'b1; tick(); tick();
    check("arst_idle", ctl_all, 15'h0);
    mul_hang = 1'b0;

    // Randomized programs.
    for (int iter = 0; iter < 12; iter++) begin
      gen_random_prog();
      do_reset(); model_run(); run_to_halt(600); check_results();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
